// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised-width ALU with a valid/ready operand handshake.
// Single-cycle ops complete on the accept edge. MUL is an iterative shift-add
// multiply that takes WIDTH cycles in the MUL state.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake; in_ready is high only in IDLE
//   a, b, sel_alu     operands and 4-bit op select, sampled only at accept
//   out_valid         one-cycle pulse when result/cout/zout are freshly valid
//   result/cout/zout  registered result, carry/borrow/overflow flag, zero flag
//   busy              multiply in progress
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel_alu,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zout,
  output logic             busy
);

  localparam logic [3:0] OpAdd   = 4'b0001;
  localparam logic [3:0] OpSub   = 4'b0010;
  localparam logic [3:0] OpNor   = 4'b0011;
  localparam logic [3:0] OpShr   = 4'b0100;
  localparam logic [3:0] OpShl   = 4'b0101;
  localparam logic [3:0] OpPassA = 4'b0110;
  localparam logic [3:0] OpPassB = 4'b0111;
  localparam logic [3:0] OpMul   = 4'b1000;
  localparam logic [3:0] OpAdc   = 4'b1001;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 cout_q, cout_d;
  logic                 zout_q, zout_d;
  logic                 c_flag_q, c_flag_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;

  logic [WIDTH:0]       alu_wide;
  logic                 alu_loads_c;
  logic [2*WIDTH-1:0]   acc_sum;

  // Single-cycle datapath, evaluated on the live inputs; only used at accept.
  always_comb begin
    alu_wide    = '0;
    alu_loads_c = 1'b0;
    case (sel_alu)
      OpAdd: begin
        alu_wide    = {1'b0, a} + {1'b0, b};
        alu_loads_c = 1'b1;
      end
      OpSub: begin
        alu_wide    = {1'b0, a} - {1'b0, b};
        alu_loads_c = 1'b1;
      end
      OpNor:   alu_wide = {1'b0, ~(a | b)};
      OpShr:   alu_wide = {2'b00, a[WIDTH-1:1]};
      OpShl: begin
        alu_wide    = {a, 1'b0};
        alu_loads_c = 1'b1;
      end
      OpPassA: alu_wide = {1'b0, a};
      OpPassB: alu_wide = {1'b0, b};
      OpAdc: begin
        alu_wide    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_flag_q};
        alu_loads_c = 1'b1;
      end
      default: alu_wide = '0;
    endcase
  end

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cout_d   = cout_q;
    zout_d   = zout_q;
    c_flag_d = c_flag_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (sel_alu == OpMul) begin
            state_d  = StMul;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
          end else begin
            state_d  = StDone;
            result_d = alu_wide[WIDTH-1:0];
            cout_d   = alu_wide[WIDTH];
            zout_d   = (alu_wide[WIDTH-1:0] == '0);
            if (alu_loads_c) c_flag_d = alu_wide[WIDTH];
          end
        end
      end
      StMul: begin
        // One multiplier bit per cycle, LSB first.
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = StDone;
          cnt_d    = '0;
          result_d = acc_sum[WIDTH-1:0];
          cout_d   = |acc_sum[2*WIDTH-1:WIDTH];
          zout_d   = (acc_sum[WIDTH-1:0] == '0);
          c_flag_d = |acc_sum[2*WIDTH-1:WIDTH];
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      cout_q   <= 1'b0;
      zout_q   <= 1'b1;
      c_flag_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zout_q   <= zout_d;
      c_flag_q <= c_flag_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StMul);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign cout      = cout_q;
  assign zout      = zout_q;

endmodule
